shift_issue: RTL and testbench
==============================

# shift_issue

Command buffer and result register wrapped around the 16-bit combinational shifter. Accepts shift commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Presents the head command to the shifter and captures the shifter result into a registered output with its own valid/ready handshake. This decouples the shifter from producer and consumer stalls, and the shifter's combinational path ends at a flop.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  command accepted when in_valid && in_ready at clk edge
- in_data  in  16  operand
- in_amt  in  4  shift amount 0..15
- in_dir  in  1  0 = left, 1 = right
- in_arith  in  1  1 = arithmetic (sign fill on right shift)
- sh_a  out  16  operand to shifter
- sh_s  out  4  amount to shifter
- sh_w  out  1  direction to shifter
- sh_l  out  1  arithmetic select to shifter
- sh_b  in  16  shifter result (combinational function of sh_*)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready at clk edge
- out_data  out  16  registered result
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO entry = {data, amt, dir, arith}, 22 bits. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- push = in_valid && in_ready; in_ready = (count != DEPTH). in_ready is registered-state only, with no path from out_ready.
- sh_* = head entry fields when count > 0, else all zero.
- Shifter semantics for the reference model:
  - left: zero fill.
  - right with arith = 0: zero fill.
  - right with arith = 1: fill with bit 15.
  - arith is ignored on left shifts.
- load = (count > 0) && (!out_valid || out_ready).
- On load:
  - out_data <= sh_b
  - out_valid <= 1
  - FIFO pops the head.
- When out_valid && out_ready && !load, out_valid <= 0 and out_data holds its value.
- When out_valid && !out_ready, out_data and out_valid hold.
- Occupancy update per edge:
  - push && !pop: count + 1
  - pop && !push: count − 1
  - both: count unchanged, with both pointers advancing.
- A push into an empty FIFO cannot pop in the same cycle. The entry must be registered first.
- Full with a simultaneous pop: in_ready stays low that cycle and rises the next cycle.
- Results leave in strict acceptance order; there are no drops and no duplicates.

## Timing
- Reset (async assert, sync-safe deassert by system):
  - count = 0, pointers = 0
  - out_valid = 0, out_data = 16'h0000
  - in_ready = 1
  - sh_* = 0
- Reset mid-operation discards all queued commands and any pending result immediately.
- Latency: a command accepted at edge N yields out_valid = 1 with its result after edge N+1, provided the output is free.
- Throughput: one result per cycle with out_ready held high and in_valid high every cycle. In steady state count toggles between 0 and 1 only.
- Storage capacity under full backpressure is DEPTH + 1 commands: DEPTH in the FIFO plus one in the output register.
- The shifter path (head mux → shifter → out_data D input) is the critical path and must close in one cycle.

## Test plan
- Reset: push 3 commands with out_ready = 0, then pulse rst mid-cycle → out_valid = 0, count = 0, in_ready = 1 immediately. The next output is the first post-reset command.
- Right arithmetic: in_data = 16'h8001, amt = 4, dir = 1, arith = 1 → out_data = 16'hF800 one cycle after accept. The same command with arith = 0 → 16'h0800.
- Left and edge amounts:
  - 16'h00FF, amt = 8, dir = 0 → 16'hFF00.
  - 16'h8000, amt = 15, dir = 1, arith = 1 → 16'hFFFF.
  - amt = 0 → result equals operand.
- Backpressure: out_ready = 0 with in_valid held high.
  - Expect 5 accepts, then in_ready = 0 with count = 4 (DEPTH = 4).
  - Raise out_ready → 5 results in acceptance order, one per cycle.
  - in_ready returns 1 the cycle after the first pop.
- Streaming: out_ready = 1, 16 back-to-back commands of 16'hA5A5 with amt 0..15, alternating dir and arith.
  - Expect 16 consecutive out_valid cycles, no bubbles, count ≤ 1.
  - Every result must match the reference model.
- Random: random in_valid and out_ready over 10k cycles → scoreboard matches in order, and count never exceeds DEPTH.

Source files
------------

// File: rtl/shift_issue.sv
// shift_issue: command FIFO in front of an external 16-bit combinational
// shifter, with a registered result stage behind it. The FIFO head drives the
// shifter. The shifter output is captured into out_data, so the shifter path
// ends at a flop and is isolated from producer and consumer stalls.
module shift_issue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_data,
  input  logic [3:0]                   in_amt,
  input  logic                         in_dir,
  input  logic                         in_arith,
  output logic [15:0]                  sh_a,
  output logic [3:0]                   sh_s,
  output logic                         sh_w,
  output logic                         sh_l,
  input  logic [15:0]                  sh_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  amt;
    logic        dir;
    logic        arith;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  cmd_t          head;
  logic          not_empty;
  logic          push;
  logic          load;

  // The producer-side handshake depends only on registered occupancy, so
  // there is no combinational path from out_ready to in_ready.
  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // A load needs an entry that is already stored. A command pushed into an
  // empty FIFO therefore waits one edge before it can be loaded.
  assign load      = not_empty && (!out_valid || out_ready);

  // Present the head entry to the shifter. All fields are zero when empty.
  always_comb begin
    head = '0;
    if (not_empty) head = mem[rd_ptr];
  end

  assign sh_a = head.data;
  assign sh_s = head.amt;
  assign sh_w = head.dir;
  assign sh_l = head.arith;

  // Write the accepted command into the FIFO storage.
  // NOTE: the storage array has no reset. Occupancy alone decides which
  // entries are valid, so stale contents are never observed, and leaving it
  // unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: in_data, amt: in_amt, dir: in_dir, arith: in_arith};
  end

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      if (push && !load)      count <= count + CW'(1);
      else if (load && !push) count <= count - CW'(1);
    end
  end

  // Result register: capture the shifter output on load, and clear valid
  // once the consumer takes a result with nothing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sh_b;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Testbench for shift_issue. It supplies the combinational shifter and keeps
// a queue-based behavioural model that is compared with the DUT every cycle.
// Directed cases use hand-computed literal results.
`timescale 1ns/1ps
module tb_shift_issue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [3:0]    in_amt;
  logic          in_dir;
  logic          in_arith;
  logic [15:0]   sh_a;
  logic [3:0]    sh_s;
  logic          sh_w;
  logic          sh_l;
  logic [15:0]   sh_b;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_arith(in_arith),
    .sh_a(sh_a), .sh_s(sh_s), .sh_w(sh_w), .sh_l(sh_l), .sh_b(sh_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  // Shifter expressed as arithmetic: multiply or divide by 2**amt. An
  // arithmetic right shift of a negative value adds the sign-fill bits.
  function automatic logic [15:0] shf(input logic [15:0] d, input int a,
                                      input logic dir, input logic arith);
    int p;
    int v;
    p = 1 << a;
    if (!dir)           v = (int'(d) * p) % 65536;
    else if (!arith)    v = int'(d) / p;
    else if (d[15])     v = int'(d) / p + (65536 - 65536 / p);
    else                v = int'(d) / p;
    return 16'(v);
  endfunction

  assign sh_b = shf(sh_a, int'(sh_s), sh_w, sh_l);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic        dir;
    logic        ar;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        c;
  logic        m_ov;
  logic [15:0] m_od;
  logic        m_rdy, m_push, m_load;
  int          m_acc, m_res;

  // The model advances on each edge from the inputs it sees there.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_od = 16'h0000;
    end else begin
      m_rdy  = (q.size() != DEPTH);
      m_push = in_valid && m_rdy;
      m_load = (q.size() > 0) && (!m_ov || out_ready);
      if (m_ov && out_ready) m_res++;
      if (m_load) begin
        c    = q.pop_front();
        m_od = shf(c.d, int'(c.a), c.dir, c.ar);
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_push) begin
        q.push_back('{d: in_data, a: in_amt, dir: in_dir, ar: in_arith});
        m_acc++;
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, (q.size() != DEPTH));
      check("count", count, q.size());
      check("count_le_depth", count <= DEPTH, 1);
      check("out_valid", out_valid, m_ov);
      check("out_data", out_data, m_od);
      check("sh_a", sh_a, q.size() > 0 ? q[0].d : 16'h0);
      check("sh_s", sh_s, q.size() > 0 ? q[0].a : 4'h0);
      check("sh_w", sh_w, q.size() > 0 ? q[0].dir : 1'b0);
      check("sh_l", sh_l, q.size() > 0 ? q[0].ar : 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
  endtask

  // Send one command into an idle block and check its result one cycle after
  // acceptance.
  task automatic send_one(input logic [15:0] d, input logic [3:0] a, input logic dir,
                          input logic ar, input logic [15:0] exp, input string name);
    int waited;
    out_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_ready"}, in_ready, 1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir; in_arith = ar;
    tick();
    in_valid = 1'b0;
    tick();
    check({name, "_valid"}, out_valid, 1);
    check(name, out_data, exp);
    tick();
  endtask

  cmd_t exp_q[$];
  int   accepts;
  int   acc_cnt, res_cnt;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; in_arith = 1'b0;
    out_ready = 1'b0;
    m_acc = 0; m_res = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sh_a", sh_a, 16'h0000);
    rst = 1'b0;
    tick();

    // Shifter cases with literal results.
    send_one(16'h8001, 4'd4, 1'b1, 1'b1, 16'hF800, "rasr_8001_4");
    send_one(16'h8001, 4'd4, 1'b1, 1'b0, 16'h0800, "rlsr_8001_4");
    send_one(16'h00FF, 4'd8, 1'b0, 1'b0, 16'hFF00, "lsl_00ff_8");
    send_one(16'h8000, 4'd15, 1'b1, 1'b1, 16'hFFFF, "rasr_8000_15");
    send_one(16'h1234, 4'd0, 1'b1, 1'b1, 16'h1234, "amt0");
    send_one(16'h8421, 4'd3, 1'b0, 1'b1, 16'h2108, "lsl_ignores_arith");

    // Reset mid-operation.
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0100 + 16'(i); in_amt = 4'd1; in_dir = 1'b0; in_arith = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_in_ready", in_ready, 1);
    #3 rst = 1'b0;
    tick();
    send_one(16'h1234, 4'd4, 1'b0, 1'b0, 16'h2340, "post_reset_first");

    // Backpressure: DEPTH in the FIFO plus one in the output register.
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepts   = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      in_data = 16'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom); in_arith = 1'($urandom);
      if (in_ready) begin
        exp_q.push_back('{d: in_data, a: in_amt, dir: in_dir, ar: in_arith});
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", accepts, DEPTH + 1);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_count_full", count, DEPTH);
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      check("bp_drain_valid", out_valid, 1);
      if (k < exp_q.size())
        check("bp_drain_data", out_data,
              shf(exp_q[k].d, int'(exp_q[k].a), exp_q[k].dir, exp_q[k].ar));
      tick();
      if (k == 0) check("bp_in_ready_after_pop", in_ready, 1);
    end
    check("bp_empty_after", out_valid, 0);

    // Streaming: back-to-back commands, no bubbles, occupancy stays at 0 or 1.
    drain();
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; in_data = 16'hA5A5; in_amt = 4'(i);
        in_dir = 1'(i % 2); in_arith = 1'((i / 2) % 2);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) check("stream_valid", out_valid, 1);
      check("stream_count_le1", count <= 1, 1);
    end
    tick();
    check("stream_done", out_valid, 0);

    // Random traffic; the model checks order and contents every cycle.
    drain();
    acc_cnt = m_acc;
    res_cnt = m_res;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = 16'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom); in_arith = 1'($urandom);
      tick();
    end
    drain();
    check("rand_results_eq_accepts", m_res - res_cnt, m_acc - acc_cnt);
    check("rand_some_traffic", (m_acc - acc_cnt) > 1000, 1);
    check("rand_final_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
